// File: rtl/edge_to_level.sv
// Rebuilds a clean level from rising/falling edge event pulses, holding each
// level for a minimum width and reporting the duration of every high phase.
module edge_to_level #(
  parameter int MIN_HIGH = 2,
  parameter int MIN_LOW  = 2,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r_edge,
  input  logic          f_edge,
  output logic          a_o,
  output logic          busy,
  output logic [CW-1:0] hi_len,
  output logic          len_valid,
  output logic          err
);

  localparam logic [CW-1:0] MIN_HI_C = MIN_HIGH[CW-1:0];
  localparam logic [CW-1:0] MIN_LO_C = MIN_LOW[CW-1:0];
  localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt;
  logic          on_ev;
  logic          off_ev;
  logic          min_ok;
  logic          toggle;
  logic          busy_nxt;
  logic          err_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + ONE_C;
  endfunction

  // In either level, "on" is the event that would move a_o away from its
  // current value and "off" is the event that would keep it there.
  always_comb begin
    on_ev    = a_o ? f_edge : r_edge;
    off_ev   = a_o ? r_edge : f_edge;
    min_ok   = a_o ? (cnt >= MIN_HI_C) : (cnt >= MIN_LO_C);
    toggle   = 1'b0;
    busy_nxt = busy;
    err_nxt  = err;
    if (r_edge && f_edge) begin
      err_nxt = 1'b1;
    end else if (busy && min_ok) begin
      busy_nxt = 1'b0;
      if (!off_ev) toggle = 1'b1;
    end else if (on_ev) begin
      if (busy)        err_nxt  = 1'b1;
      else if (min_ok) toggle   = 1'b1;
      else             busy_nxt = 1'b1;
    end else if (off_ev) begin
      if (busy) busy_nxt = 1'b0;
      else      err_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_o       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cnt       <= MIN_LO_C;
      hi_len    <= '0;
      len_valid <= 1'b0;
    end else begin
      a_o       <= a_o ^ toggle;
      busy      <= busy_nxt;
      err       <= err_nxt;
      cnt       <= toggle ? ONE_C : sat_inc(cnt);
      len_valid <= toggle && a_o;
      if (toggle && a_o) hi_len <= cnt;
    end
  end

endmodule
